// File: rtl/run_length_monitor.sv
// Edge detector and run-length meter for a single sampled bit; reports each complete run.
// Registered outputs: an edge sampled at posedge k is reported during the following cycle; no backpressure.
module run_length_monitor #(
  parameter int CNT_W   = 8,
  parameter int MIN_RUN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_1,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             run_valid,
  output logic             run_level,
  output logic [CNT_W-1:0] run_len,
  output logic             run_sat,
  output logic             run_short,
  output logic [CNT_W-1:0] edge_cnt
);

  typedef enum logic [1:0] {
    PRIME = 2'd0,
    SYNC  = 2'd1,
    RUN   = 2'd2
  } state_t;

  typedef struct packed {
    logic             level;
    logic [CNT_W-1:0] len;
    logic             sat;
    logic             shrt;
  } run_rpt_t;

  localparam logic [CNT_W-1:0] LEN_MAX   = '1;
  localparam logic [CNT_W-1:0] MIN_RUN_L = CNT_W'(MIN_RUN);
  localparam logic [CNT_W-1:0] LEN_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic             prev_q;
  logic [CNT_W-1:0] len_q, len_d;
  logic             sat_q, sat_d;
  logic             cur_level, cur_level_d;
  logic [CNT_W-1:0] edge_cnt_d;
  logic             rise_d, fall_d, valid_d;
  run_rpt_t         rpt_q, rpt_d;
  logic             edge_det;

  assign edge_det = (in_1 != prev_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PRIME;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PRIME:   state_d = SYNC;
      SYNC:    if (edge_det) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = PRIME;
    endcase
  end

  // The run in progress when SYNC is entered has an unknown start, so only edges after it close reportable runs.
  always_comb begin
    len_d       = len_q;
    sat_d       = sat_q;
    cur_level_d = cur_level;
    edge_cnt_d  = edge_cnt;
    rise_d      = 1'b0;
    fall_d      = 1'b0;
    valid_d     = 1'b0;
    rpt_d       = rpt_q;
    case (state_q)
      SYNC: begin
        if (edge_det) begin
          rise_d      = in_1;
          fall_d      = ~in_1;
          edge_cnt_d  = edge_cnt + 1'b1;
          cur_level_d = in_1;
          len_d       = LEN_ONE;
          sat_d       = 1'b0;
        end
      end
      RUN: begin
        if (edge_det) begin
          valid_d     = 1'b1;
          rpt_d.level = cur_level;
          rpt_d.len   = len_q;
          rpt_d.sat   = sat_q;
          rpt_d.shrt  = (len_q < MIN_RUN_L);
          rise_d      = in_1;
          fall_d      = ~in_1;
          edge_cnt_d  = edge_cnt + 1'b1;
          cur_level_d = in_1;
          len_d       = LEN_ONE;
          sat_d       = 1'b0;
        end else if (len_q == LEN_MAX) begin
          sat_d = 1'b1;
        end else begin
          len_d = len_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q     <= 1'b0;
      len_q      <= '0;
      sat_q      <= 1'b0;
      cur_level  <= 1'b0;
      edge_cnt   <= '0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      run_valid  <= 1'b0;
      rpt_q      <= '0;
    end else begin
      prev_q     <= in_1;
      len_q      <= len_d;
      sat_q      <= sat_d;
      cur_level  <= cur_level_d;
      edge_cnt   <= edge_cnt_d;
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
      run_valid  <= valid_d;
      rpt_q      <= rpt_d;
    end
  end

  assign run_level = rpt_q.level;
  assign run_len   = rpt_q.len;
  assign run_sat   = rpt_q.sat;
  assign run_short = rpt_q.shrt;

endmodule

// File: tb/tb_run_length_monitor.sv
// Bench for run_length_monitor: scenario tasks queue expected run reports, a negedge monitor pops and compares them.
module tb_run_length_monitor;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_1;
  logic             rise_pulse, fall_pulse, run_valid, run_level, run_sat, run_short;
  logic [CNT_W-1:0] run_len, edge_cnt;

  typedef struct packed {
    logic             lvl;
    logic [CNT_W-1:0] len;
    logic             sat;
    logic             shrt;
  } rpt_t;

  rpt_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   rise_cnt = 0, fall_cnt = 0, rv_cnt = 0;
  int   cyc = 0, rise_cyc = 0, fall_cyc = 0;

  always #5 clk = ~clk;

  run_length_monitor #(.CNT_W(CNT_W), .MIN_RUN(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_1       (in_1),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .run_valid  (run_valid),
    .run_level  (run_level),
    .run_len    (run_len),
    .run_sat    (run_sat),
    .run_short  (run_short),
    .edge_cnt   (edge_cnt)
  );

  always @(negedge clk) begin
    rpt_t got, want;
    cyc++;
    if (rise_pulse === 1'b1 && fall_pulse === 1'b1) begin
      errors++;
      $display("FAIL pulse_excl: rise and fall both high at cycle %0d, required at most one", cyc);
    end
    if (rise_pulse === 1'b1) begin rise_cnt++; rise_cyc = cyc; end
    if (fall_pulse === 1'b1) begin fall_cnt++; fall_cyc = cyc; end
    if (run_valid === 1'b1) begin
      rv_cnt++;
      checks++;
      got = {run_level, run_len, run_sat, run_short};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL report_unexpected: cycle %0d got level=%0b len=%0d sat=%0b short=%0b, required no report",
                 cyc, run_level, run_len, run_sat, run_short);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL report: cycle %0d got level=%0b len=%0d sat=%0b short=%0b, required level=%0b len=%0d sat=%0b short=%0b",
                   cyc, got.lvl, got.len, got.sat, got.shrt, want.lvl, want.len, want.sat, want.shrt);
        end
      end
    end
  end

  task automatic drive(input logic v, input int n);
    in_1 = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n, input logic v);
    rst  = 1'b1;
    in_1 = v;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_counts();
    rise_cnt = 0;
    fall_cnt = 0;
    rv_cnt   = 0;
  endtask

  task automatic push(input logic lvl, input logic [CNT_W-1:0] len, input logic sat, input logic shrt);
    exp_q.push_back({lvl, len, sat, shrt});
  endtask

  task automatic test_reset();
    do_reset(3, 1'b0);
    #1;
    checks++;
    if ({rise_pulse, fall_pulse, run_valid, run_level, run_len, run_sat, run_short, edge_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rise=%0b fall=%0b valid=%0b level=%0b len=%0d sat=%0b short=%0b edge_cnt=%0d, required all 0",
               rise_pulse, fall_pulse, run_valid, run_level, run_len, run_sat, run_short, edge_cnt);
    end
  endtask

  task automatic test_square();
    clear_counts();
    drive(1'b0, 5);
    drive(1'b1, 5);
    push(1'b1, 8'd5, 1'b0, 1'b0); drive(1'b0, 5);
    push(1'b0, 8'd5, 1'b0, 1'b0); drive(1'b1, 5);
    push(1'b1, 8'd5, 1'b0, 1'b0); drive(1'b0, 5);
    push(1'b0, 8'd5, 1'b0, 1'b0); drive(1'b1, 5);
    #1;
    checks++;
    if (edge_cnt !== 8'd5) begin errors++; $display("FAIL square_edge_cnt: got %0d, required 5", edge_cnt); end
    checks++;
    if (rv_cnt != 4) begin errors++; $display("FAIL square_reports: got %0d, required 4", rv_cnt); end
    checks++;
    if (rise_cnt != 3 || fall_cnt != 2) begin
      errors++; $display("FAIL square_pulses: got rise=%0d fall=%0d, required rise=3 fall=2", rise_cnt, fall_cnt);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL square_pending: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_saturation();
    do_reset(2, 1'b0);
    clear_counts();
    drive(1'b0, 3);
    drive(1'b1, 300);
    push(1'b1, 8'd255, 1'b1, 1'b0); drive(1'b0, 4);
    push(1'b0, 8'd4, 1'b0, 1'b0);   drive(1'b1, 2);
    #1;
    checks++;
    if (fall_cnt != 1 || rise_cnt != 2) begin
      errors++; $display("FAIL sat_pulses: got rise=%0d fall=%0d, required rise=2 fall=1", rise_cnt, fall_cnt);
    end
    checks++;
    if (edge_cnt !== 8'd3) begin errors++; $display("FAIL sat_edge_cnt: got %0d, required 3", edge_cnt); end
    checks++;
    if (run_sat !== 1'b0 || run_len !== 8'd4) begin
      errors++; $display("FAIL sat_held: got sat=%0b len=%0d, required sat=0 len=4", run_sat, run_len);
    end
    checks++;
    if (rv_cnt != 2 || exp_q.size() != 0) begin
      errors++; $display("FAIL sat_reports: got %0d reports %0d pending, required 2 and 0", rv_cnt, exp_q.size());
    end
  endtask

  task automatic test_glitch();
    do_reset(1, 1'b1);
    clear_counts();
    drive(1'b1, 2);
    drive(1'b0, 3);
    push(1'b0, 8'd3, 1'b0, 1'b0); drive(1'b1, 1);
    push(1'b1, 8'd1, 1'b0, 1'b1); drive(1'b0, 3);
    #1;
    checks++;
    if (fall_cyc - rise_cyc != 1) begin
      errors++; $display("FAIL glitch_spacing: got fall-rise=%0d cycles, required 1", fall_cyc - rise_cyc);
    end
    checks++;
    if (rise_cnt != 1 || fall_cnt != 2 || edge_cnt !== 8'd3) begin
      errors++; $display("FAIL glitch_edges: got rise=%0d fall=%0d edge_cnt=%0d, required 1 2 3", rise_cnt, fall_cnt, edge_cnt);
    end
    checks++;
    if (rv_cnt != 2 || exp_q.size() != 0) begin
      errors++; $display("FAIL glitch_reports: got %0d reports %0d pending, required 2 and 0", rv_cnt, exp_q.size());
    end
  endtask

  task automatic test_mid_reset();
    do_reset(1, 1'b0);
    clear_counts();
    drive(1'b0, 2);
    drive(1'b1, 5);
    push(1'b1, 8'd5, 1'b0, 1'b0); drive(1'b0, 5);
    push(1'b0, 8'd5, 1'b0, 1'b0); drive(1'b1, 2);
    #1;
    checks++;
    if (rv_cnt != 2) begin errors++; $display("FAIL midrst_before: got %0d reports, required 2", rv_cnt); end
    clear_counts();
    do_reset(1, 1'b1);
    #1;
    checks++;
    if ({rise_pulse, fall_pulse, run_valid, run_level, run_len, run_sat, run_short, edge_cnt} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got rise=%0b fall=%0b valid=%0b level=%0b len=%0d sat=%0b short=%0b edge_cnt=%0d, required all 0",
               rise_pulse, fall_pulse, run_valid, run_level, run_len, run_sat, run_short, edge_cnt);
    end
    drive(1'b1, 3);
    #1;
    checks++;
    if (rise_cnt + fall_cnt + rv_cnt != 0) begin
      errors++; $display("FAIL midrst_quiet: got rise=%0d fall=%0d valid=%0d, required none", rise_cnt, fall_cnt, rv_cnt);
    end
    drive(1'b0, 4);
    push(1'b0, 8'd4, 1'b0, 1'b0); drive(1'b1, 3);
    push(1'b1, 8'd3, 1'b0, 1'b0); drive(1'b0, 2);
    #1;
    checks++;
    if (edge_cnt !== 8'd3 || rv_cnt != 2 || exp_q.size() != 0) begin
      errors++; $display("FAIL midrst_after: got edge_cnt=%0d reports=%0d pending=%0d, required 3 2 0", edge_cnt, rv_cnt, exp_q.size());
    end
  endtask

  task automatic test_constant();
    do_reset(2, 1'b1);
    clear_counts();
    drive(1'b1, 50);
    #1;
    checks++;
    if (rise_cnt + fall_cnt + rv_cnt != 0) begin
      errors++; $display("FAIL const_quiet: got rise=%0d fall=%0d valid=%0d, required none", rise_cnt, fall_cnt, rv_cnt);
    end
    checks++;
    if (edge_cnt !== 8'd0) begin errors++; $display("FAIL const_edge_cnt: got %0d, required 0", edge_cnt); end
  endtask

  task automatic test_back_to_back();
    logic v;
    do_reset(1, 1'b0);
    clear_counts();
    drive(1'b0, 2);
    for (int i = 0; i < 260; i++) begin
      v = (i % 2 == 0);
      if (i > 0) push((i % 2) == 1, 8'd1, 1'b0, 1'b1);
      drive(v, 1);
      if (i == 255) begin
        #1;
        checks++;
        if (edge_cnt !== 8'd0) begin errors++; $display("FAIL wrap_zero: got edge_cnt=%0d after 256 edges, required 0", edge_cnt); end
      end
    end
    #1;
    checks++;
    if (edge_cnt !== 8'd4) begin errors++; $display("FAIL wrap_final: got edge_cnt=%0d, required 4", edge_cnt); end
    checks++;
    if (rise_cnt != 130 || fall_cnt != 130) begin
      errors++; $display("FAIL wrap_pulses: got rise=%0d fall=%0d, required 130 130", rise_cnt, fall_cnt);
    end
    checks++;
    if (rv_cnt != 259 || exp_q.size() != 0) begin
      errors++; $display("FAIL wrap_reports: got %0d reports %0d pending, required 259 and 0", rv_cnt, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_square();
    test_saturation();
    test_glitch();
    test_mid_reset();
    test_constant();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
